// File: rtl/mem_arbiter.sv
// Shares the 8-bit RAM bus between IF word fetches (4 byte reads, done 6 cycles after grant) and SLB byte accesses (read ack +3, write ack +2).
// rdy_in low freezes everything; IO writes wait in IDLE while the IO buffer is full; a flush aborts reads but never a store.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE    = 32'h30000,
    parameter int          FAIR_LIMIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        control_hazard,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        slb_req,
    input  logic        slb_wr,
    input  logic [31:0] slb_addr,
    input  logic [7:0]  slb_dout,
    output logic        slb_ack,
    output logic [7:0]  slb_din,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_RD  = 2'd1;
    localparam logic [1:0] S_SLB_RD = 2'd2;
    localparam logic [1:0] S_SLB_WR = 2'd3;

    localparam int FW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [FW-1:0] fair_cnt;
    logic [23:0]   byte_buf;
    logic          wr_q;

    logic slb_blocked;
    logic slb_ok;
    logic if_ok;
    logic grant_if;
    logic grant_slb;

    assign slb_blocked = slb_wr && (slb_addr >= IO_BASE) && io_buffer_full;
    assign slb_ok      = slb_req && !slb_ack && !slb_blocked;
    assign if_ok       = if_req && !if_done;
    assign grant_if    = (state == S_IDLE) && if_ok && (!slb_ok || (fair_cnt == FW'(FAIR_LIMIT)));
    assign grant_slb   = (state == S_IDLE) && slb_ok && !grant_if;

    // The RAM is frozen by the same rdy_in, so a held strobe must not write twice.
    assign mem_wr = wr_q & rdy_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            fair_cnt <= '0;
            byte_buf <= 24'd0;
            wr_q     <= 1'b0;
            if_done  <= 1'b0;
            if_data  <= 32'd0;
            slb_ack  <= 1'b0;
            slb_din  <= 8'd0;
            mem_dout <= 8'd0;
            mem_a    <= 32'd0;
        end else if (rdy_in) begin
            if_done <= 1'b0;
            slb_ack <= 1'b0;
            wr_q    <= 1'b0;

            if (control_hazard || !if_req || grant_if)
                fair_cnt <= '0;
            else if (grant_slb)
                fair_cnt <= fair_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (grant_if) begin
                        state <= S_IF_RD;
                        mem_a <= if_addr;
                        cnt   <= 3'd0;
                    end else if (grant_slb) begin
                        mem_a <= slb_addr;
                        cnt   <= 3'd0;
                        if (slb_wr) begin
                            state    <= S_SLB_WR;
                            mem_dout <= slb_dout;
                            wr_q     <= 1'b1;
                        end else begin
                            state <= S_SLB_RD;
                        end
                    end
                end
                S_IF_RD: begin
                    if (control_hazard) begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt < 3'd3)
                            mem_a <= if_addr + 32'(cnt) + 32'd1;
                        // mem_din carries the byte addressed one cycle earlier.
                        case (cnt)
                            3'd1: byte_buf[7:0]   <= mem_din;
                            3'd2: byte_buf[15:8]  <= mem_din;
                            3'd3: byte_buf[23:16] <= mem_din;
                            3'd4: begin
                                if_data <= {mem_din, byte_buf};
                                if_done <= 1'b1;
                                state   <= S_IDLE;
                                cnt     <= 3'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_SLB_RD: begin
                    if (control_hazard) begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                    end else if (cnt == 3'd0) begin
                        cnt <= 3'd1;
                    end else begin
                        slb_din <= mem_din;
                        slb_ack <= 1'b1;
                        state   <= S_IDLE;
                        cnt     <= 3'd0;
                    end
                end
                default: begin
                    // Stores are already committed, so a flush never cancels them.
                    slb_ack <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM controller that shares the 8-bit unified memory bus between instruction fetch (IF) and the store/load buffer.
- IF gets whole 32-bit words, assembled from 4 byte reads. The store/load buffer gets one byte per handshake and sequences multi-byte accesses itself.
- Handles IO write back-pressure, speculative-flush aborts and a bounded-starvation priority scheme.

Parameters:
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO space.
- FAIR_LIMIT, 2, max consecutive SLB grants while if_req is pending before IF is forced.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-high reset
- rdy_in  input  1  global ready; low freezes the block
- control_hazard  input  1  branch flush from ROB commit
- io_buffer_full  input  1  IO output buffer full
- if_req  input  1  IF word-read request, held until if_done
- if_addr  input  32  IF word address
- if_done  output  1  one-cycle pulse; if_data valid
- if_data  output  32  little-endian word {b3,b2,b1,b0}
- slb_req  input  1  SLB byte request, held until slb_ack
- slb_wr  input  1  1 = write
- slb_addr  input  32  byte address
- slb_dout  input  8  write data
- slb_ack  output  1  one-cycle pulse; byte done, slb_din valid for reads
- slb_din  output  8  read byte
- mem_din  input  8  RAM read data, 1 cycle after address
- mem_dout  output  8  RAM write data (registered)
- mem_a  output  32  RAM address (registered)
- mem_wr  output  1  RAM write strobe: registered strobe AND rdy_in

Behaviour:
- Reset:
  - state=IDLE, cnt=0, fair_cnt=0.
  - All outputs 0; mem_a=0.
- rdy_in low: every register holds and mem_wr is forced 0. The RAM is frozen by the same rdy_in.
- States: IDLE, IF_RD, SLB_RD, SLB_WR.
- IDLE grant (evaluated at the clock edge):
  - SLB is granted if slb_req is high, slb_ack is not high this cycle, and the request is not blocked.
  - A request is blocked when slb_wr=1, slb_addr>=IO_BASE and io_buffer_full=1. A blocked request stays IDLE and does not count as a grant.
  - IF is granted instead if if_req is high, if_done is not high this cycle, and one of: no SLB grant is possible, or fair_cnt==FAIR_LIMIT.
  - fair_cnt increments on each SLB grant while if_req is high. It clears on an IF grant, or when if_req is low.
- IF_RD (request sampled at end of cycle T):
  - mem_a = if_addr+cnt in cycles T+1..T+4, with cnt 0..3.
  - The byte for address k arrives on mem_din one cycle later and is stored to buf[8k+7:8k].
  - At end of T+5, if_data <= {mem_din, buf[23:0]} and if_done <= 1.
  - Cycle T+6: if_done=1, state=IDLE. Latency is 6 cycles. Address increments wrap modulo 2^32.
- SLB_RD:
  - mem_a = slb_addr in cycle T+1; mem_din is valid in T+2.
  - End of T+2: slb_din <= mem_din, slb_ack <= 1. Ack is in cycle T+3, state=IDLE.
- SLB_WR:
  - mem_a=slb_addr, mem_dout=slb_dout, mem_wr=1 in cycle T+1 only.
  - slb_ack is high in T+2. Exactly one write strobe per grant.
- In an ack/done cycle, the same requester is not re-granted. The requester updates its request on that edge; the other requester may be granted.
- control_hazard (sampled at edge, when rdy_in=1):
  - IF_RD or SLB_RD goes to IDLE immediately, with no if_done/slb_ack. An if_done or slb_ack being set at that same edge is suppressed.
  - SLB_WR is never aborted (stores are committed); it completes its strobe and ack.
  - fair_cnt clears.
- mem_wr is 0 in every state except the single SLB_WR strobe cycle. mem_a/mem_dout hold their last value in IDLE.
- Async reset mid-transaction: immediate return to reset values, with no strobe or ack.

Test Plan:
- IF alone, if_addr=0x1000, RAM bytes 11,22,33,44 → mem_a 0x1000..0x1003 in cycles T+1..T+4; if_done in T+6 with if_data=0x44332211.
- SLB read 0x20 (RAM=0xA5) and if_req asserted together → SLB is granted first; slb_ack in T+3 with slb_din=0xA5; IF is granted at the end of T+3.
- SLB write 0x30000 data 0x41 with io_buffer_full=1 for 5 cycles → no mem_wr, IF still served; after release, exactly one mem_wr with mem_dout=0x41 and mem_a=0x30000.
- control_hazard in cycle T+3 of an IF_RD → no if_done, IDLE next cycle, no stale if_done later. Hazard during SLB_WR → write and ack still occur.
- Back-to-back SLB reads with if_req held → IF is granted after 2 SLB grants (FAIR_LIMIT=2), then SLB resumes.
- rdy_in low for 3 cycles mid IF_RD → mem_a frozen, mem_wr=0, if_data correct, latency extended by exactly 3 cycles. Async reset mid-SLB_WR → mem_wr=0 immediately.
